// File: rtl/arbiter_types.sv
// Types shared by the memory arbiter and anything that observes its state.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        INST = 2'b01,
        DATA = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rv32i_types.sv
// Shared word-level types for the RV32I core and its memory-side blocks.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data share one memory
// port. Data wins by default; a starvation counter forces a waiting fetch
// through after STARVE_LIMIT consecutive data grants. Each granted transaction
// is registered onto the memory port and held until mem_resp, and the response
// pulse is routed only to the requester that owns the transaction.
module mem_arbiter
    import rv32i_types::*;
    import arbiter_types::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            inst_read,
    input  rv32i_word       inst_address,
    output logic            inst_resp,
    output rv32i_word       inst_rdata,

    input  logic            data_read,
    input  logic            data_write,
    input  logic [3:0]      data_byte_enable,
    input  rv32i_word       data_address,
    input  rv32i_word       data_wdata,
    output logic            data_resp,
    output rv32i_word       data_rdata,

    output logic            mem_read,
    output logic            mem_write,
    output logic [3:0]      mem_byte_enable,
    output rv32i_word       mem_address,
    output rv32i_word       mem_wdata,
    input  logic            mem_resp,
    input  rv32i_word       mem_rdata
);

    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(STARVE_LIMIT);
    localparam logic             GUARD_EN_C = (STARVE_LIMIT != 0);

    arb_state_t        state_r;
    arb_state_t        state_nx_s;
    logic              data_req_s;
    logic              force_inst_s;
    logic              grant_inst_s;
    logic              grant_data_s;
    logic [CNT_W-1:0]  streak_r;

    logic              mem_read_r;
    logic              mem_write_r;
    logic [3:0]        mem_byte_enable_r;
    rv32i_word         mem_address_r;
    rv32i_word         mem_wdata_r;

    // Increment that sticks at the starvation limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val >= LIMIT_C) begin
            sat_inc = LIMIT_C;
        end else begin
            sat_inc = val + CNT_W'(1);
        end
    endfunction

    assign data_req_s   = data_read | data_write;
    assign force_inst_s = inst_read & data_req_s & GUARD_EN_C & (streak_r == LIMIT_C);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant decision in IDLE and return-to-IDLE on completion.
    always_comb begin
        state_nx_s   = state_r;
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (force_inst_s) begin
                    state_nx_s   = INST;
                    grant_inst_s = 1'b1;
                end else if (data_req_s) begin
                    state_nx_s   = DATA;
                    grant_data_s = 1'b1;
                end else if (inst_read) begin
                    state_nx_s   = INST;
                    grant_inst_s = 1'b1;
                end else begin
                    state_nx_s   = IDLE;
                end
            end
            INST, DATA: begin
                if (mem_resp) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Transaction register: latch on grant, hold until completion, then drop strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_r        <= 1'b0;
            mem_write_r       <= 1'b0;
            mem_byte_enable_r <= 4'b0000;
            mem_address_r     <= 32'h0000_0000;
            mem_wdata_r       <= 32'h0000_0000;
        end else if (grant_inst_s) begin
            mem_read_r        <= 1'b1;
            mem_write_r       <= 1'b0;
            mem_byte_enable_r <= 4'b1111;
            mem_address_r     <= inst_address;
            mem_wdata_r       <= 32'h0000_0000;
        end else if (grant_data_s) begin
            // A simultaneous read+write is illegal; the write takes precedence.
            mem_read_r        <= data_read & ~data_write;
            mem_write_r       <= data_write;
            mem_byte_enable_r <= data_byte_enable;
            mem_address_r     <= data_address;
            mem_wdata_r       <= data_wdata;
        end else if ((state_r != IDLE) && mem_resp) begin
            mem_read_r        <= 1'b0;
            mem_write_r       <= 1'b0;
        end else begin
            mem_read_r        <= mem_read_r;
            mem_write_r       <= mem_write_r;
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_r <= '0;
        end else if (grant_inst_s) begin
            streak_r <= '0;
        end else if (grant_data_s) begin
            if (inst_read) begin
                streak_r <= sat_inc(streak_r);
            end else begin
                streak_r <= '0;
            end
        end else begin
            streak_r <= streak_r;
        end
    end

    // Responses go only to the owner; a mem_resp seen in IDLE is dropped.
    assign inst_resp  = mem_resp & (state_r == INST);
    assign data_resp  = mem_resp & (state_r == DATA);
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    assign mem_read        = mem_read_r;
    assign mem_write       = mem_write_r;
    assign mem_byte_enable = mem_byte_enable_r;
    assign mem_address     = mem_address_r;
    assign mem_wdata       = mem_wdata_r;

endmodule
